// File: rtl/seq_gen_pkg.sv
// seq_pkg: shared constants for the sequence generator and its downstream detector.
// Holds the FSM state encoding, the default pattern width/value and a helper
// that sizes bit-index fields.
package seq_pkg;
    localparam int PAT_W = 16;
    localparam logic [PAT_W-1:0] DEF_PAT = 16'b0000_1101_1001_0101;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/seq_gen_if.sv
// seq_gen_if: control/data bundle between a pattern source and seq_gen.
// master: drives start, stop, loop_mode, pat_in, pat_valid; sees the outputs.
// slave : seq_gen side, drives pat_ready, seq_bit, bit_valid, bit_idx, busy, done.
interface seq_gen_if #(parameter int PAT_W = seq_pkg::PAT_W);
    import seq_pkg::*;
    localparam int IDX_W = idx_w(PAT_W);
    logic             start;
    logic             stop;
    logic             loop_mode;
    logic [PAT_W-1:0] pat_in;
    logic             pat_valid;
    logic             pat_ready;
    logic             seq_bit;
    logic             bit_valid;
    logic [IDX_W-1:0] bit_idx;
    logic             busy;
    logic             done;
    modport master (output start, stop, loop_mode, pat_in, pat_valid,
                    input  pat_ready, seq_bit, bit_valid, bit_idx, busy, done);
    modport slave  (input  start, stop, loop_mode, pat_in, pat_valid,
                    output pat_ready, seq_bit, bit_valid, bit_idx, busy, done);
endinterface

// File: rtl/seq_gen_tick_gen.sv
// tick_gen: clock divider producing one tick every DIV enabled clk cycles.
// Ports: clk, rst_n (async, active-low), clr (zero the count), en (count), tick (out).
module tick_gen #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    assign tick  = en && cnt_q == CW'(DIV - 1);
    assign cnt_d = (clr || !en || tick) ? '0 : cnt_q + CW'(1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/seq_gen.sv
// seq_gen: serialises a stored pattern MSB first, DIV clk cycles per bit.
// Ports: clk, rst_n (async, active-low), bus (seq_gen_if.slave: start/stop/
// loop_mode/pat_in/pat_valid in; pat_ready/seq_bit/bit_valid/bit_idx/busy/done out).
module seq_gen #(
    parameter int               PAT_W   = seq_pkg::PAT_W,
    parameter int unsigned      DIV     = 1,
    parameter logic [PAT_W-1:0] DEF_PAT = seq_pkg::DEF_PAT
) (
    input logic       clk,
    input logic       rst_n,
    seq_gen_if.slave  bus
);
    import seq_pkg::*;
    localparam int IDX_W = idx_w(PAT_W);
    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic [PAT_W-1:0] pat_q, sh;
    logic             run, tick, last;
    assign run  = state_q == RUN;
    assign last = idx_q == IDX_W'(PAT_W - 1);
    // divider held clear outside RUN so the first bit always gets DIV cycles
    tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (!run),
        .en   (run),
        .tick (tick)
    );
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (bus.start && !bus.stop) begin
                    state_d = RUN;
                    valid_d = 1'b1;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (tick) begin
                    idx_d   = last ? '0 : idx_q + IDX_W'(1);
                    valid_d = !last || bus.loop_mode;
                    state_d = (last && !bus.loop_mode) ? FINISH : RUN;
                end
            end
            FINISH: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            pat_q   <= DEF_PAT;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            if (bus.pat_valid && state_q == IDLE) pat_q <= bus.pat_in;
        end
    end
    // current bit is the MSB of the pattern shifted left by the bit index
    assign sh            = pat_q << idx_q;
    assign bus.seq_bit   = run & sh[PAT_W-1];
    assign bus.bit_valid = valid_q;
    assign bus.bit_idx   = idx_q;
    assign bus.busy      = run;
    assign bus.done      = state_q == FINISH;
    assign bus.pat_ready = state_q == IDLE;
endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 The block SHALL have parameter PAT_W, default 16, the pattern length in bits.
REQ-002 The block SHALL have parameter DIV, default 1, the number of clk cycles per output bit (legal range 1..2^24).
REQ-003 The block SHALL have parameter DEF_PAT, default 16'b0000_1101_1001_0101, the pattern held after reset.
REQ-004 clk  input  1  system clock, 50 MHz, rising-edge active.
REQ-005 rst_n  input  1  reset: asynchronous, active-low.
REQ-006 start  input  1  begin transmission of the stored pattern.
REQ-007 stop  input  1  abort transmission.
REQ-008 loop_mode  input  1  1 = repeat pattern continuously; 0 = single pass.
REQ-009 pat_in  input  PAT_W  new pattern.
REQ-010 pat_valid  input  1  pat_in is valid.
REQ-011 pat_ready  output  1  block accepts a new pattern.
REQ-012 seq_bit  output  1  serial pattern bit, MSB first; feeds the downstream sequence detector.
REQ-013 bit_valid  output  1  one-cycle strobe on each clk where seq_bit takes a new bit.
REQ-014 bit_idx  output  clog2(PAT_W)  index of the bit currently driven (0 = MSB).
REQ-015 busy  output  1  high in RUN.
REQ-016 done  output  1  one-cycle pulse at the end of a single pass.

Function
REQ-017 FSM states SHALL be IDLE, RUN and FINISH; no other states are reachable; an illegal encoding SHALL return to IDLE.
REQ-018 pat_ready SHALL equal (state == IDLE); a pattern SHALL load into pat_reg only when pat_valid && pat_ready; pat_valid outside IDLE SHALL be ignored.
REQ-019 IDLE -> RUN on start; start and a pattern load in the same cycle SHALL transmit the newly loaded pat_in.
REQ-020 On the first RUN cycle: seq_bit = pattern[PAT_W-1], bit_idx = 0, bit_valid = 1, divider cleared (latency start -> first bit: 1 clk).
REQ-021 In RUN, the tick_gen divider SHALL assert a tick every DIV clk cycles; each tick SHALL advance bit_idx by 1, drive the next bit and pulse bit_valid; every bit SHALL be held exactly DIV cycles.
REQ-022 On a tick with bit_idx == PAT_W-1: if loop_mode = 1, bit_idx SHALL wrap to 0 and drive the MSB without a gap; otherwise the FSM SHALL go to FINISH.
REQ-023 FINISH SHALL last one cycle: done = 1, seq_bit = 0, bit_valid = 0; then IDLE.
REQ-024 stop in RUN SHALL force IDLE next cycle, seq_bit = 0, with no done pulse; stop wins over a simultaneous start or tick.
REQ-025 start while in RUN or FINISH SHALL be ignored; loop_mode SHALL be sampled on each wrap tick, so clearing it mid-pass ends transmission after the current pass.
REQ-026 In IDLE, seq_bit SHALL be 0, bit_valid 0 and bit_idx 0.
REQ-027 With DIV = 1, bit_valid SHALL be high on every RUN cycle (one bit per clk).

Reset
REQ-028 rst_n low SHALL immediately set: state IDLE, pat_reg = DEF_PAT, seq_bit 0, bit_valid 0, bit_idx 0, busy 0, done 0, pat_ready 1, divider 0.
REQ-029 Reset asserted mid-RUN SHALL abort without a done pulse; after release, the block SHALL wait for a new start.

Structure
REQ-030 A shared package seq_pkg SHALL hold the state encoding constants, PAT_W and DEF_PAT; the downstream detector uses the same package.
REQ-031 The clock divider SHALL be the sub-module tick_gen (inputs: clk, rst_n, clr, en; output: tick); all other logic SHALL be in seq_gen.

Verification
REQ-032 Reset, DIV=1, loop_mode=0, start pulse -> seq_bit 0000110110010101 on 16 consecutive cycles, bit_valid high on all 16, done on cycle 17, then IDLE with pat_ready=1.
REQ-033 DIV=4, loop_mode=1, load pat_in=16'hA5F0 -> each bit held 4 cycles, bit_valid every 4th cycle, bit 15 followed directly by bit 0 (1), done never asserted.
REQ-034 stop asserted at bit_idx=7 -> IDLE next cycle, seq_bit=0, done=0; pat_valid=1 with 16'hFFFF while busy -> pattern unchanged on the next run.
REQ-035 start and pat_valid in the same IDLE cycle with pat_in=16'h8001 -> output is 1, then fourteen 0s, then 1.
REQ-036 rst_n pulled low at bit_idx=9 -> all outputs at reset values within the same cycle; default pattern restored.
REQ-037 System check, DIV=1, default pattern into the downstream detector -> exactly one detection for the 10110 at bits 5..9.
